// File: rtl/microwatt_soc_wrapper.sv
// Bring-up shell: timed boot sequence drives a GPIO signature and a UART banner,
// then echoes UART0 bytes. SPI flash is parked and JTAG is a 1-bit BYPASS chain.
module microwatt_soc_wrapper #(
  parameter int unsigned BOOT_DELAY = 16,
  parameter logic [31:0] GPIO_INIT  = 32'h12345678,
  parameter int unsigned CLK_DIV    = 16,
  parameter logic [7:0]  BANNER     = 8'h4D
) (
  input  logic        ext_clk,
  input  logic        ext_rst,
  input  logic        uart0_rxd,
  output logic        uart0_txd,
  output logic        spi_flash_cs_n,
  output logic        spi_flash_clk,
  output logic        spi_flash_sdat_o,
  input  logic        spi_flash_sdat_i,
  output logic        spi_flash_sdat_oe,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_dir,
  input  logic        jtag_tck,
  input  logic        jtag_tdi,
  input  logic        jtag_tms,
  input  logic        jtag_trst,
  output logic        jtag_tdo
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned BOOT_W = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY);

  typedef enum logic [1:0] {BOOT_WAIT, BOOT_SIG, BOOT_BANNER, BOOT_RUN} bootState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

  bootState_e        bootState_q;
  logic [BOOT_W-1:0] bootCnt_q;
  logic [31:0]       gpioOut_q;
  logic [31:0]       gpioDir_q;
  logic              bannerSent_q;

  logic              txBusy_q;
  logic              txd_q;
  logic [8:0]        txShift_q;
  logic [3:0]        txBit_q;
  logic [DIV_W-1:0]  txDiv_q;
  logic              txStart;
  logic              echoStart;
  logic [7:0]        txData;

  rxState_e          rxState_q;
  logic              rxMeta_q;
  logic              rxSync_q;
  logic              rxLast_q;
  logic [DIV_W-1:0]  rxDiv_q;
  logic [2:0]        rxBit_q;
  logic [7:0]        rxShift_q;
  logic              holdValid_q;
  logic [7:0]        holdData_q;

  logic              tckMeta_q, tckSync_q, tckLast_q;
  logic              tdiMeta_q, tdiSync_q;
  logic              trstMeta_q, trstSync_q;
  logic              bypass_q;
  logic              tdo_q;

  logic [31:0]       gpioIn_q;
  logic              unusedInputs;

  // Boot sequencer; the banner is only issued once, then RUN is terminal.
  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      bootState_q  <= BOOT_WAIT;
      bootCnt_q    <= '0;
      gpioOut_q    <= '0;
      gpioDir_q    <= '0;
      bannerSent_q <= 1'b0;
    end else begin
      case (bootState_q)
        BOOT_WAIT: begin
          if (bootCnt_q == BOOT_LAST) bootState_q <= BOOT_SIG;
          else                        bootCnt_q   <= bootCnt_q + 1'b1;
        end
        BOOT_SIG: begin
          gpioOut_q   <= GPIO_INIT;
          gpioDir_q   <= '1;
          bootState_q <= BOOT_BANNER;
        end
        BOOT_BANNER: begin
          if (txStart)                        bannerSent_q <= 1'b1;
          else if (bannerSent_q && !txBusy_q) bootState_q  <= BOOT_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    txStart   = 1'b0;
    echoStart = 1'b0;
    txData    = holdData_q;
    if (!txBusy_q) begin
      if (bootState_q == BOOT_BANNER && !bannerSent_q) begin
        txStart = 1'b1;
        txData  = BANNER;
      end else if (bootState_q == BOOT_RUN && holdValid_q) begin
        txStart   = 1'b1;
        echoStart = 1'b1;
      end
    end
  end

  // 8N1 transmitter: the start bit goes out on the same edge the byte is accepted.
  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      txBusy_q  <= 1'b0;
      txd_q     <= 1'b1;
      txShift_q <= '1;
      txBit_q   <= '0;
      txDiv_q   <= '0;
    end else if (!txBusy_q) begin
      if (txStart) begin
        txBusy_q  <= 1'b1;
        txd_q     <= 1'b0;
        txShift_q <= {1'b1, txData};
        txBit_q   <= '0;
        txDiv_q   <= '0;
      end
    end else if (txDiv_q == DIV_LAST) begin
      txDiv_q <= '0;
      if (txBit_q == 4'd9) begin
        txBusy_q <= 1'b0;
      end else begin
        txd_q     <= txShift_q[0];
        txShift_q <= {1'b1, txShift_q[8:1]};
        txBit_q   <= txBit_q + 1'b1;
      end
    end else begin
      txDiv_q <= txDiv_q + 1'b1;
    end
  end

  // Receiver samples mid-bit; a new byte in the holding register beats a same-cycle echo clear.
  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      rxState_q   <= RX_IDLE;
      rxMeta_q    <= 1'b1;
      rxSync_q    <= 1'b1;
      rxLast_q    <= 1'b1;
      rxDiv_q     <= '0;
      rxBit_q     <= '0;
      rxShift_q   <= '0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
    end else begin
      rxMeta_q <= uart0_rxd;
      rxSync_q <= rxMeta_q;
      rxLast_q <= rxSync_q;
      if (echoStart) holdValid_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (rxLast_q && !rxSync_q) begin
            rxState_q <= RX_START;
            rxDiv_q   <= '0;
          end
        end
        RX_START: begin
          if (rxDiv_q == DIV_HALF) begin
            rxDiv_q <= '0;
            if (rxSync_q) begin
              rxState_q <= RX_IDLE;
            end else begin
              rxState_q <= RX_DATA;
              rxBit_q   <= '0;
            end
          end else begin
            rxDiv_q <= rxDiv_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxDiv_q == DIV_LAST) begin
            rxDiv_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[7:1]};
            if (rxBit_q == 3'd7) rxState_q <= RX_STOP;
            else                 rxBit_q   <= rxBit_q + 1'b1;
          end else begin
            rxDiv_q <= rxDiv_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rxDiv_q == DIV_LAST) begin
            rxDiv_q   <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q) begin
              holdValid_q <= 1'b1;
              holdData_q  <= rxShift_q;
            end
          end else begin
            rxDiv_q <= rxDiv_q + 1'b1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // JTAG BYPASS: tck/tdi share the same synchroniser depth so they stay aligned.
  always_ff @(posedge ext_clk) begin
    if (ext_rst) begin
      tckMeta_q  <= 1'b0;
      tckSync_q  <= 1'b0;
      tckLast_q  <= 1'b0;
      tdiMeta_q  <= 1'b0;
      tdiSync_q  <= 1'b0;
      trstMeta_q <= 1'b0;
      trstSync_q <= 1'b0;
      bypass_q   <= 1'b0;
      tdo_q      <= 1'b0;
    end else begin
      tckMeta_q  <= jtag_tck;
      tckSync_q  <= tckMeta_q;
      tckLast_q  <= tckSync_q;
      tdiMeta_q  <= jtag_tdi;
      tdiSync_q  <= tdiMeta_q;
      trstMeta_q <= jtag_trst;
      trstSync_q <= trstMeta_q;
      if (!trstSync_q) begin
        bypass_q <= 1'b0;
        tdo_q    <= 1'b0;
      end else if (tckSync_q && !tckLast_q) begin
        bypass_q <= tdiSync_q;
      end else if (!tckSync_q && tckLast_q) begin
        tdo_q <= bypass_q;
      end
    end
  end

  always_ff @(posedge ext_clk) begin
    if (ext_rst) gpioIn_q <= '0;
    else         gpioIn_q <= gpio_in;
  end

  assign unusedInputs      = ^{gpioIn_q, spi_flash_sdat_i, jtag_tms};

  assign uart0_txd         = txd_q;
  assign gpio_out          = gpioOut_q;
  assign gpio_dir          = gpioDir_q;
  assign jtag_tdo          = tdo_q;
  assign spi_flash_cs_n    = 1'b1;
  assign spi_flash_clk     = 1'b0;
  assign spi_flash_sdat_o  = 1'b0;
  assign spi_flash_sdat_oe = 1'b0;

endmodule

// File: tb/tb_microwatt_soc_wrapper.sv
// Directed bench for microwatt_soc_wrapper: boot timing, banner frame, UART echo,
// RX glitch/framing rejection, JTAG bypass and mid-boot reset.
module tb_microwatt_soc_wrapper;

  localparam int          BD        = 16;
  localparam int          CD        = 16;
  localparam logic [31:0] SIG_VALUE = 32'h12345678;
  localparam logic [7:0]  BANNER_B  = 8'h4D;

  logic        ext_clk;
  logic        ext_rst;
  logic        uart0_rxd;
  logic        uart0_txd;
  logic        spi_flash_cs_n;
  logic        spi_flash_clk;
  logic        spi_flash_sdat_o;
  logic        spi_flash_sdat_i;
  logic        spi_flash_sdat_oe;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic        jtag_tck;
  logic        jtag_tdi;
  logic        jtag_tms;
  logic        jtag_trst;
  logic        jtag_tdo;

  int errors = 0;
  int checks = 0;
  int edgeCnt = 0;
  bit spiBad = 1'b0;

  microwatt_soc_wrapper #(
    .BOOT_DELAY(BD),
    .GPIO_INIT (SIG_VALUE),
    .CLK_DIV   (CD),
    .BANNER    (BANNER_B)
  ) dut (
    .ext_clk          (ext_clk),
    .ext_rst          (ext_rst),
    .uart0_rxd        (uart0_rxd),
    .uart0_txd        (uart0_txd),
    .spi_flash_cs_n   (spi_flash_cs_n),
    .spi_flash_clk    (spi_flash_clk),
    .spi_flash_sdat_o (spi_flash_sdat_o),
    .spi_flash_sdat_i (spi_flash_sdat_i),
    .spi_flash_sdat_oe(spi_flash_sdat_oe),
    .gpio_in          (gpio_in),
    .gpio_out         (gpio_out),
    .gpio_dir         (gpio_dir),
    .jtag_tck         (jtag_tck),
    .jtag_tdi         (jtag_tdi),
    .jtag_tms         (jtag_tms),
    .jtag_trst        (jtag_trst),
    .jtag_tdo         (jtag_tdo)
  );

  initial begin
    ext_clk = 1'b0;
    forever #5 ext_clk = ~ext_clk;
  end

  // Edges since reset release; after the k-th released edge (0-based) it reads k+1.
  always @(posedge ext_clk) begin
    if (ext_rst) edgeCnt <= 0;
    else         edgeCnt <= edgeCnt + 1;
  end

  always @(negedge ext_clk) begin
    if (spi_flash_cs_n !== 1'b1 || spi_flash_clk !== 1'b0 ||
        spi_flash_sdat_o !== 1'b0 || spi_flash_sdat_oe !== 1'b0)
      spiBad <= 1'b1;
  end

  initial begin
    repeat (200000) @(posedge ext_clk);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge ext_clk);
  endtask

  task automatic waitTxStart(input int maxWait, output bit found, output int startCnt);
    found    = 1'b0;
    startCnt = 0;
    for (int i = 0; i < maxWait && !found; i++) begin
      @(negedge ext_clk);
      if (uart0_txd == 1'b0) begin
        found    = 1'b1;
        startCnt = edgeCnt;
      end
    end
  endtask

  // Decodes one TX frame by sampling each bit in its middle.
  task automatic captureFrame(input int maxWait, output bit found, output int startCnt,
                              output logic [7:0] data, output logic stopBit);
    data    = '0;
    stopBit = 1'b0;
    waitTxStart(maxWait, found, startCnt);
    if (found) begin
      waitCycles(CD / 2);
      for (int k = 0; k < 8; k++) begin
        waitCycles(CD);
        data = {uart0_txd, data[7:1]};
      end
      waitCycles(CD);
      stopBit = uart0_txd;
    end
  endtask

  // Sends one 8N1 frame on rxd; call at a negedge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart0_rxd = frame[0];
      frame     = frame >> 1;
      waitCycles(CD);
    end
    uart0_rxd = 1'b1;
    waitCycles(CD);
  endtask

  // Call at the negedge where reset was released.
  task automatic checkSignature(input string prefix);
    waitCycles(BD + 1);
    checkOutput({prefix, " gpio_out before signature"}, gpio_out, 32'h0);
    waitCycles(1);
    checkOutput({prefix, " gpio_out signature"}, gpio_out, SIG_VALUE);
    checkOutput({prefix, " gpio_dir signature"}, gpio_dir, 32'hFFFFFFFF);
  endtask

  bit          found, found2;
  int          startCnt, startCnt2;
  logic [7:0]  rxByte, rxByte2;
  logic        stopBit, stopBit2;
  logic [169:0] gotWave, expWave;
  logic [9:0]  frameSh;
  logic        waveBit;
  logic [3:0]  patSh;
  logic        prevBit;
  int          remain;

  initial begin
    ext_rst          = 1'b1;
    uart0_rxd        = 1'b1;
    spi_flash_sdat_i = 1'b0;
    gpio_in          = 32'h0;
    jtag_tck         = 1'b0;
    jtag_tdi         = 1'b0;
    jtag_tms         = 1'b0;
    jtag_trst        = 1'b1;

    waitCycles(3);
    checkOutput("reset gpio_out", gpio_out, 32'h0);
    checkOutput("reset gpio_dir", gpio_dir, 32'h0);
    checkOutput("reset txd", uart0_txd, 1'b1);
    checkOutput("reset tdo", jtag_tdo, 1'b0);

    gpio_in = 32'hDEADBEEF;
    ext_rst = 1'b0;
    checkSignature("boot");

    waitTxStart(50, found, startCnt);
    checkOutput("banner start found", found, 1'b1);
    checkOutput("banner start edge", startCnt, BD + 3);
    gotWave = '0;
    expWave = '0;
    frameSh = {1'b1, BANNER_B, 1'b0};
    for (int i = 0; i < 170; i++) begin
      if (i > 0) @(negedge ext_clk);
      gotWave = {uart0_txd, gotWave[169:1]};
      waveBit = (i < 160) ? frameSh[0] : 1'b1;
      expWave = {waveBit, expWave[169:1]};
      if (i % CD == CD - 1) frameSh = frameSh >> 1;
    end
    checkOutput("banner waveform", gotWave, expWave);

    fork
      applyStimulus(8'hA5, 1'b1);
      captureFrame(400, found, startCnt, rxByte, stopBit);
    join
    checkOutput("echo A5 found", found, 1'b1);
    checkOutput("echo A5 data", rxByte, 8'hA5);
    checkOutput("echo A5 stop", stopBit, 1'b1);

    fork
      applyStimulus(8'h3C, 1'b0);
      captureFrame(400, found, startCnt, rxByte, stopBit);
    join
    checkOutput("framing error no echo", found, 1'b0);

    uart0_rxd = 1'b0;
    waitCycles(4);
    uart0_rxd = 1'b1;
    captureFrame(300, found, startCnt, rxByte, stopBit);
    checkOutput("glitch no echo", found, 1'b0);
    checkOutput("glitch txd idle", uart0_txd, 1'b1);

    fork
      applyStimulus(8'h5A, 1'b1);
      captureFrame(400, found, startCnt, rxByte, stopBit);
    join
    checkOutput("echo 5A after glitch", rxByte, 8'h5A);

    checkOutput("tdo before shift", jtag_tdo, 1'b0);
    patSh   = 4'b1101;
    prevBit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      jtag_tdi = (i < 4) ? patSh[0] : 1'b0;
      jtag_tck = 1'b0;
      waitCycles(5);
      if (i > 0) checkOutput($sformatf("tdo bit %0d", i - 1), jtag_tdo, prevBit);
      waitCycles(5);
      jtag_tck = 1'b1;
      waitCycles(10);
      prevBit = patSh[0];
      patSh   = patSh >> 1;
    end
    jtag_trst = 1'b0;
    waitCycles(5);
    checkOutput("tdo cleared by trst", jtag_tdo, 1'b0);
    jtag_trst = 1'b1;
    waitCycles(5);
    jtag_tdi = 1'b1;
    jtag_tck = 1'b0;
    waitCycles(6);
    checkOutput("tdo after trst fall edge", jtag_tdo, 1'b0);

    remain = 10000 - edgeCnt;
    if (remain > 0) waitCycles(remain);
    checkOutput("gpio_out held in RUN", gpio_out, SIG_VALUE);
    checkOutput("gpio_dir held in RUN", gpio_dir, 32'hFFFFFFFF);

    ext_rst = 1'b1;
    waitCycles(2);
    ext_rst = 1'b0;
    checkSignature("reboot");
    waitTxStart(50, found, startCnt);
    checkOutput("reboot banner found", found, 1'b1);
    waitCycles(40);
    checkOutput("mid banner txd low", uart0_txd, 1'b0);
    ext_rst = 1'b1;
    waitCycles(1);
    checkOutput("abort txd high", uart0_txd, 1'b1);
    checkOutput("abort gpio_out", gpio_out, 32'h0);
    checkOutput("abort gpio_dir", gpio_dir, 32'h0);
    waitCycles(2);
    ext_rst = 1'b0;

    fork
      checkSignature("restart");
      applyStimulus(8'h3C, 1'b1);
      begin
        captureFrame(100, found, startCnt, rxByte, stopBit);
        captureFrame(400, found2, startCnt2, rxByte2, stopBit2);
      end
    join
    checkOutput("restart banner found", found, 1'b1);
    checkOutput("restart banner edge", startCnt, BD + 3);
    checkOutput("restart banner data", rxByte, BANNER_B);
    checkOutput("held byte echo found", found2, 1'b1);
    checkOutput("held byte echo data", rxByte2, 8'h3C);

    waitCycles(2);
    checkOutput("spi parked", spiBad, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microwatt_soc_wrapper.md
Name: microwatt_soc_wrapper

Overview:
Top-level shell around a minimal Microwatt-style boot controller for bring-up.
- Runs a fixed boot sequence from reset: waits a programmable delay, then drives a known signature on the GPIO port and sends a banner byte over UART0.
- Echoes any byte received on UART0.
- Keeps the SPI flash interface parked.
- Provides a 1-bit JTAG BYPASS path so the scan chain stays intact.

Parameters:
- BOOT_DELAY, 16: cycles after reset release before the signature is driven.
- GPIO_INIT, 32'h12345678: boot signature written to gpio_out.
- CLK_DIV, 16: ext_clk cycles per UART bit, for both TX and RX. Minimum 4.
- BANNER, 8'h4D: byte transmitted once at boot (ASCII 'M').

Ports:
- ext_clk  in  1  sole clock; all logic on its rising edge.
- ext_rst  in  1  synchronous, active-high reset.
- uart0_rxd  in  1  UART receive, idle high.
- uart0_txd  out  1  UART transmit, idle high.
- spi_flash_cs_n  out  1  flash chip select, active low.
- spi_flash_clk  out  1  flash clock.
- spi_flash_sdat_o  out  1  flash data out.
- spi_flash_sdat_i  in  1  flash data in (unused).
- spi_flash_sdat_oe  out  1  flash data output enable.
- gpio_in  in  32  GPIO inputs (sampled, no functional effect).
- gpio_out  out  32  GPIO output register.
- gpio_dir  out  32  GPIO direction, 1 = output.
- jtag_tck  in  1  JTAG clock, sampled by ext_clk.
- jtag_tdi  in  1  JTAG data in.
- jtag_tms  in  1  JTAG mode select (ignored; BYPASS only).
- jtag_trst  in  1  JTAG reset, active low.
- jtag_tdo  out  1  JTAG data out.

Behaviour:

Reset (ext_rst=1, synchronous):
- gpio_out=0, gpio_dir=0.
- uart0_txd=1; all counters cleared.
- Boot FSM goes to WAIT.
- jtag_tdo=0; bypass register=0.
- ext_rst has priority over every other event. Asserting it mid-boot or mid-byte aborts the operation; txd returns high on the next edge.

Boot FSM (WAIT -> SIG -> BANNER -> RUN):
- WAIT: count BOOT_DELAY cycles after reset deasserts, then go to SIG.
- SIG: one cycle; load gpio_out=GPIO_INIT and gpio_dir=32'hFFFFFFFF. Go to BANNER.
- BANNER: start TX of BANNER; go to RUN when the TX stop bit completes.
- RUN: terminal state; gpio_out/gpio_dir hold their values until reset.
- Signature timing: visible at the edge BOOT_DELAY+1 cycles after the first edge with ext_rst=0.

UART TX:
- Format 8N1, LSB first; each bit is held CLK_DIV cycles.
- Frame = start(0), d0..d7, stop(1): 10*CLK_DIV cycles total.
- tx_busy is an internal signal; a new byte starts the cycle after the stop bit ends.

UART RX:
- Two-flop synchroniser on uart0_rxd.
- A falling edge while idle starts a frame. Re-check at CLK_DIV/2; if the line is high, treat as a glitch and return to idle.
- Sample data bits at subsequent CLK_DIV intervals.
- Stop bit sampled 0: framing error; byte discarded.
- Valid byte: buffered in a 1-entry holding register.

Echo (RUN only):
- When TX is idle and the holding register is full, transmit the held byte and clear the register.
- A second byte arriving while the register is full overwrites it (last wins).
- Bytes received before RUN are held and echoed once RUN is entered.

SPI flash (constant):
- cs_n=1, clk=0, sdat_o=0, sdat_oe=0; sdat_i ignored.

JTAG:
- Two-flop synchronise tck/tdi/trst.
- trst low: clear the bypass register and tdo.
- tck synced rising edge: bypass <= tdi.
- tck synced falling edge: tdo <= bypass.
- tms ignored.

gpio_in: registered each cycle; no effect on outputs.

Test Plan:
1. Reset 1 cycle, rxd=1, trst=1, inputs 0 -> gpio_out=0 during WAIT; gpio_out=32'h12345678 and gpio_dir=32'hFFFFFFFF from cycle BOOT_DELAY+1 onward; still 12345678 at 10000 cycles.
2. Boot banner -> txd start bit begins after SIG; decoded byte 8'h4D; frame length 160 cycles (CLK_DIV=16); txd idles high afterward.
3. After RUN, send 8'hA5 on rxd at CLK_DIV -> same 8'hA5 echoed on txd. Stop bit forced 0 -> no echo.
4. Glitch: rxd low for 4 cycles only -> no byte received, txd stays high.
5. JTAG: toggle tck (period 20 cycles) with tdi pattern 1,0,1,1 -> tdo shows the same pattern delayed one tck; trst=0 clears tdo to 0.
6. Assert ext_rst mid-banner -> txd=1, gpio_out=0 next edge; boot restarts and the signature reappears after BOOT_DELAY+1 cycles; SPI pins constant throughout (cs_n=1, oe=0).
